// File: rtl/hbridge_output_stage.sv
// Dual-motor H-bridge output stage: PWM generation, dead-time-protected direction
// changes, filtered overcurrent trip with cooldown, retry counting and latched lockout.
module hbridge_output_stage #(
  parameter int PRESCALE        = 6510,
  parameter int DEAD_CYCLES     = 50000,
  parameter int OC_FILTER       = 1000,
  parameter int COOLDOWN_CYCLES = 20000000,
  parameter int MAX_RETRY       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dir_cmd,
  input  logic [7:0] duty,
  input  logic [1:0] cur_lim_n,
  input  logic       fault_clr,
  output logic [3:0] hb_out,
  output logic [1:0] state_o,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 2);
  localparam int OW = $clog2(OC_FILTER + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_TRIP = 2'b01,
    ST_LOCK = 2'b10
  } state_t;

  // 11 on a bridge pair is an illegal drive request and is folded to coast
  function automatic logic [1:0] coast_fold(input logic [1:0] pair);
    if (pair == 2'b11) begin
      return 2'b00;
    end else begin
      return pair;
    end
  endfunction

  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    duty_l_q, duty_l_d;
  logic [OW-1:0] oc_q, oc_d;
  state_t        state_q, state_d;
  logic [1:0]    retry_q, retry_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [CW-1:0] clean_q, clean_d;
  logic [1:0]    app_q [2];
  logic [1:0]    app_d [2];
  logic [DW-1:0] dead_q [2];
  logic [DW-1:0] dead_d [2];
  logic [1:0]    cmd [2];
  logic [3:0]    hb_q, hb_d;
  logic          fault_q, fault_d;
  logic          pwm_on;
  logic          oc_hit;
  logic          trip_ev;

  // State register for every flop in the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      pre_q     <= {PW{1'b0}};
      step_q    <= 8'd0;
      duty_l_q  <= 8'd0;
      oc_q      <= {OW{1'b0}};
      state_q   <= ST_RUN;
      retry_q   <= 2'b00;
      cool_q    <= {CW{1'b0}};
      clean_q   <= {CW{1'b0}};
      app_q[0]  <= 2'b00;
      app_q[1]  <= 2'b00;
      dead_q[0] <= {DW{1'b0}};
      dead_q[1] <= {DW{1'b0}};
      hb_q      <= 4'b0000;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pre_q     <= pre_d;
      step_q    <= step_d;
      duty_l_q  <= duty_l_d;
      oc_q      <= oc_d;
      state_q   <= state_d;
      retry_q   <= retry_d;
      cool_q    <= cool_d;
      clean_q   <= clean_d;
      app_q[0]  <= app_d[0];
      app_q[1]  <= app_d[1];
      dead_q[0] <= dead_d[0];
      dead_q[1] <= dead_d[1];
      hb_q      <= hb_d;
      fault_q   <= fault_d;
    end
  end

  // Limiter flags are asynchronous; only sync2_q is ever used downstream
  always_comb begin
    sync1_d = cur_lim_n;
    sync2_d = sync1_q;
  end

  // Prescaler, step counter, and duty latched only at the period boundary
  always_comb begin
    pre_d    = pre_q + PW'(1);
    step_d   = step_q;
    duty_l_d = duty_l_q;
    if (pre_q == PW'(PRESCALE - 1)) begin
      pre_d  = {PW{1'b0}};
      step_d = step_q + 8'd1;
      if (step_q == 8'd255) begin
        duty_l_d = duty;
      end else begin
        duty_l_d = duty_l_q;
      end
    end else begin
      step_d = step_q;
    end
  end

  assign pwm_on  = (step_q < duty_l_q);
  assign oc_hit  = (sync2_q != 2'b11);
  assign trip_ev = (state_q == ST_RUN) && oc_hit && (oc_q == OW'(OC_FILTER - 1));

  // Run/trip/lockout sequencing, overcurrent filter and retry bookkeeping
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cool_d  = cool_q;
    clean_d = {CW{1'b0}};
    oc_d    = {OW{1'b0}};
    case (state_q)
      ST_RUN: begin
        if (trip_ev) begin
          if (retry_q >= 2'(MAX_RETRY - 1)) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_TRIP;
          end
          if (retry_q == 2'b11) begin
            retry_d = retry_q;
          end else begin
            retry_d = retry_q + 2'd1;
          end
          cool_d = CW'(COOLDOWN_CYCLES - 1);
        end else begin
          if (oc_hit) begin
            oc_d = oc_q + OW'(1);
          end else begin
            oc_d = {OW{1'b0}};
          end
          // A full cooldown of clean running forgives earlier trips
          if (clean_q == CW'(COOLDOWN_CYCLES - 1)) begin
            retry_d = 2'b00;
            clean_d = {CW{1'b0}};
          end else begin
            clean_d = clean_q + CW'(1);
          end
        end
      end
      ST_TRIP: begin
        if (cool_q == {CW{1'b0}}) begin
          state_d = ST_RUN;
        end else begin
          cool_d = cool_q - CW'(1);
        end
      end
      ST_LOCK: begin
        if (fault_clr && (sync2_q == 2'b11)) begin
          state_d = ST_RUN;
          retry_d = 2'b00;
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        state_d = ST_LOCK;
      end
    endcase
  end

  // Per-motor applied direction with dead time after any leg release
  always_comb begin
    cmd[0] = coast_fold(dir_cmd[3:2]);
    cmd[1] = coast_fold(dir_cmd[1:0]);
    for (int m = 0; m < 2; m++) begin
      app_d[m]  = app_q[m];
      dead_d[m] = dead_q[m];
      if ((state_q != ST_RUN) || trip_ev) begin
        app_d[m]  = 2'b00;
        dead_d[m] = {DW{1'b0}};
      end else if (dead_q[m] != {DW{1'b0}}) begin
        // The last dead cycle hands over whatever is commanded at expiry
        dead_d[m] = dead_q[m] - DW'(1);
        if (dead_q[m] == DW'(1)) begin
          app_d[m] = cmd[m];
        end else begin
          app_d[m] = 2'b00;
        end
      end else if ((app_q[m] != 2'b00) && (cmd[m] != app_q[m])) begin
        app_d[m]  = 2'b00;
        dead_d[m] = DW'(DEAD_CYCLES);
      end else begin
        app_d[m] = cmd[m];
      end
    end
  end

  // Registered bridge drive and fault flag
  always_comb begin
    if ((state_q == ST_RUN) && !trip_ev && pwm_on) begin
      hb_d = {app_q[0], app_q[1]};
    end else begin
      hb_d = 4'b0000;
    end
    fault_d = (state_d != ST_RUN);
  end

  assign hb_out    = hb_q;
  assign state_o   = state_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_hbridge_output_stage.sv
// Bench for hbridge_output_stage: directed PWM/dead-time/trip/lockout sequences,
// a direction table, and randomized stimulus against a cycle-level reference model.
module tb_hbridge_output_stage;

  localparam int P    = 2;
  localparam int DEAD = 8;
  localparam int OCF  = 4;
  localparam int COOL = 32;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dir_cmd = 4'b0000;
  logic [7:0] duty = 8'd0;
  logic [1:0] cur_lim_n = 2'b11;
  logic       fault_clr = 1'b0;
  logic [3:0] hb_out;
  logic [1:0] state_o;
  logic       fault;
  logic [1:0] retry_cnt;

  always #5 clk = ~clk;

  hbridge_output_stage #(
    .PRESCALE(P), .DEAD_CYCLES(DEAD), .OC_FILTER(OCF),
    .COOLDOWN_CYCLES(COOL), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dir_cmd(dir_cmd), .duty(duty),
    .cur_lim_n(cur_lim_n), .fault_clr(fault_clr), .hb_out(hb_out),
    .state_o(state_o), .fault(fault), .retry_cnt(retry_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: time is the count of clock edges since reset release
  longint     ek;
  int         dl;
  logic [1:0] h1, h2;
  int         oc, ms, retry, cool, clean;
  logic [1:0] app [2];
  longint     hold [2];
  logic [3:0] hb_exp;

  typedef struct {
    logic [3:0] dir;
    logic [3:0] exp_hb;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, ek);
    end
  endtask

  function automatic logic [1:0] nrm(input logic [1:0] x);
    return (x == 2'b11) ? 2'b00 : x;
  endfunction

  task automatic model_reset();
    ek = 0; dl = 0; h1 = 2'b11; h2 = 2'b11;
    oc = 0; ms = 0; retry = 0; cool = 0; clean = 0;
    app[0] = 2'b00; app[1] = 2'b00; hold[0] = -1; hold[1] = -1;
    hb_exp = 4'b0000;
  endtask

  task automatic model_edge();
    int step;
    bit pon, hit, run, trip;
    logic [1:0] seen;
    logic [1:0] c [2];
    step = int'((ek / P) % 256);
    pon  = (step < dl);
    seen = h2; h2 = h1; h1 = cur_lim_n;
    hit  = (seen != 2'b11);
    run  = (ms == 0);
    trip = run && hit && (oc + 1 == OCF);
    hb_exp = (run && !trip && pon) ? {app[0], app[1]} : 4'b0000;
    c[0] = nrm(dir_cmd[3:2]);
    c[1] = nrm(dir_cmd[1:0]);
    for (int m = 0; m < 2; m++) begin
      if (!run || trip) begin
        app[m] = 2'b00; hold[m] = -1;
      end else if (hold[m] >= 0 && ek < hold[m]) begin
        app[m] = 2'b00;
      end else if (hold[m] >= 0 && ek == hold[m]) begin
        app[m] = c[m]; hold[m] = -1;
      end else if (app[m] != 2'b00 && c[m] != app[m]) begin
        app[m] = 2'b00; hold[m] = ek + DEAD;
      end else begin
        app[m] = c[m];
      end
    end
    if (ms == 0) begin
      if (trip) begin
        ms = (retry >= MAXR - 1) ? 2 : 1;
        retry = (retry == 3) ? 3 : retry + 1;
        cool = COOL; clean = 0; oc = 0;
      end else begin
        oc = hit ? oc + 1 : 0;
        clean++;
        if (clean == COOL) begin
          retry = 0; clean = 0;
        end
      end
    end else if (ms == 1) begin
      oc = 0; clean = 0; cool--;
      if (cool == 0) ms = 0;
    end else begin
      oc = 0; clean = 0;
      if (fault_clr && seen == 2'b11) begin
        ms = 0; retry = 0;
      end
    end
    if ((ek + 1) % (256 * P) == 0) dl = int'(duty);
    ek++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check("model_hb_out", hb_out, hb_exp);
    check("model_state", state_o, ms[1:0]);
    check("model_fault", fault, (ms != 0));
    check("model_retry", retry_cnt, retry[1:0]);
  endtask

  initial begin
    int n_on, n_off, n, burst;
    logic [3:0] exp;
    logic [1:0] pat;
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b1001, 4'b1001};
    tbl[2] = '{4'b1111, 4'b0000};
    tbl[3] = '{4'b0110, 4'b0110};
    tbl[4] = '{4'b1101, 4'b0001};
    tbl[5] = '{4'b0111, 4'b0100};
    tbl[6] = '{4'b1010, 4'b1010};
    tbl[7] = '{4'b1110, 4'b0010};

    model_reset();
    repeat (3) tick();
    check("rst_hb_out", hb_out, 4'b0000);
    check("rst_state", state_o, 2'b00);
    check("rst_fault", fault, 1'b0);
    check("rst_retry", retry_cnt, 2'b00);
    rst_n = 1'b1;
    dir_cmd = 4'b1010;
    duty = 8'd128;

    // PWM: first period runs with the reset duty of 0
    repeat (512) tick();
    n_on = 0; n_off = 0;
    for (int i = 513; i <= 1024; i++) begin
      tick();
      if (i == 600) duty = 8'd64;
      if (i <= 768) begin
        if (hb_out == 4'b1010) n_on++;
      end else begin
        if (hb_out == 4'b0000) n_off++;
      end
    end
    check("pwm128_on_cycles", n_on, 256);
    check("pwm128_off_cycles", n_off, 256);
    n_on = 0; n_off = 0;
    for (int i = 1025; i <= 1536; i++) begin
      tick();
      if (i == 1300) duty = 8'd255;
      if (i <= 1152) begin
        if (hb_out == 4'b1010) n_on++;
      end else begin
        if (hb_out == 4'b0000) n_off++;
      end
    end
    check("pwm64_on_cycles", n_on, 128);
    check("pwm64_off_cycles", n_off, 384);

    // Reversal of motor A with dead time; motor B keeps forward
    dir_cmd = 4'b0110;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = (i == 0) ? 4'b1010 : (i <= 8) ? 4'b0010 : 4'b0110;
      check("reverse_seq", hb_out, exp);
    end
    dir_cmd = 4'b1010;
    repeat (12) tick();
    // Coast then reverse inside the dead window still waits the full dead time
    dir_cmd = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) dir_cmd = 4'b0110;
      exp = (i == 0) ? 4'b1010 : (i <= 8) ? 4'b0010 : 4'b0110;
      check("coast_reverse_seq", hb_out, exp);
    end

    for (int t = 0; t < 8; t++) begin
      dir_cmd = tbl[t].dir;
      repeat (12) tick();
      check($sformatf("dir_table[%0d]", t), hb_out, tbl[t].exp_hb);
    end

    // Overcurrent filter: 3 cycles is below threshold, 4 trips
    dir_cmd = 4'b1010;
    cur_lim_n = 2'b10;
    repeat (3) tick();
    cur_lim_n = 2'b11;
    repeat (6) tick();
    check("oc3_state", state_o, 2'b00);
    check("oc3_fault", fault, 1'b0);
    cur_lim_n = 2'b10;
    repeat (4) tick();
    cur_lim_n = 2'b11;
    repeat (2) tick();
    check("oc4_hb_out", hb_out, 4'b0000);
    check("oc4_fault", fault, 1'b1);
    check("oc4_state", state_o, 2'b01);
    check("oc4_retry", retry_cnt, 2'b01);
    repeat (31) tick();
    check("trip_hold_state", state_o, 2'b01);
    tick();
    check("trip_end_state", state_o, 2'b00);
    check("trip_end_retry", retry_cnt, 2'b01);
    repeat (31) tick();
    check("clean_pre_retry", retry_cnt, 2'b01);
    tick();
    check("clean_clear_retry", retry_cnt, 2'b00);

    // Lockout after three trips with no clean run between them
    cur_lim_n = 2'b10;
    n = 0;
    while (state_o != 2'b10 && n < 200) begin
      tick();
      n++;
    end
    check("lockout_latency", n, 78);
    check("lockout_retry", retry_cnt, 2'b11);
    repeat (40) tick();
    check("lockout_hold_state", state_o, 2'b10);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tick();
    check("clr_during_oc_state", state_o, 2'b10);
    cur_lim_n = 2'b11;
    repeat (3) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_ok_state", state_o, 2'b00);
    check("clr_ok_retry", retry_cnt, 2'b00);
    check("clr_ok_fault", fault, 1'b0);

    // Asynchronous reset in the middle of a trip
    cur_lim_n = 2'b01;
    repeat (6) tick();
    check("pre_reset_state", state_o, 2'b01);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_hb_out", hb_out, 4'b0000);
    check("async_rst_state", state_o, 2'b00);
    check("async_rst_fault", fault, 1'b0);
    check("async_rst_retry", retry_cnt, 2'b00);
    model_reset();
    cur_lim_n = 2'b11;
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the model
    burst = 0;
    pat = 2'b11;
    duty = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) dir_cmd = 4'($urandom);
      if ($urandom_range(0, 255) == 0) duty = 8'($urandom);
      if (burst > 0) begin
        burst--;
      end else if ($urandom_range(0, 59) == 0) begin
        burst = $urandom_range(1, 7);
        pat = 2'($urandom_range(0, 2));
      end
      cur_lim_n = (burst > 0) ? pat : 2'b11;
      fault_clr = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
